seq_generator: RTL and testbench
================================

# seq_generator

Serial bit-pattern generator: the transmit-side counterpart of the sequence detector. Captures a parallel pattern and a length on `start`, then drives the pattern MSB-first onto a one-bit serial output, one bit per accepted clock. Uses a valid/ready handshake, and can optionally append a parity bit. Feeds detector-side blocks and benches with exact bit streams such as `1011_0000_1011_0000`.

## Interface
- `WIDTH`, default 16: pattern register width in bits.
- `LW`, default `$clog2(WIDTH+1)`: width of the length field.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send, MSB first; captured with `start`.
- `len`  in  LW  number of bits to send, from the top of `pattern`; 0 means WIDTH; values above WIDTH are clamped to WIDTH.
- `ready`  in  1  consumer accepts `out_bit` this cycle.
- `out_bit`  out  1  current serial bit.
- `out_valid`  out  1  `out_bit` is meaningful.
- `busy`  out  1  high from the cycle after `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse after the final bit is accepted.

## Operation
- FSM states are IDLE, SHIFT, PAR and DONE.
  - PAR is reachable only when `SEQGEN_PARITY_EN` is defined.
- IDLE: `start=1` captures `pattern` into the shift register and the effective length into a down-counter, clears the parity accumulator, and moves to SHIFT.
- SHIFT:
  - `out_valid=1` and `out_bit` is the shift-register MSB.
  - On `ready=1`: shift left by one, XOR the bit into parity, and decrement the counter.
  - On the last bit's acceptance, go to PAR if parity is enabled, otherwise DONE.
- SHIFT with `ready=0`: the register, counter and `out_bit` all hold. The output is stable while stalled.
- PAR: `out_valid=1` and `out_bit` is the even-parity bit. On `ready=1`, go to DONE.
- DONE: `done=1` and `busy=1` for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE, including in DONE. It is never queued.
- A changing `pattern` or `len` after capture has no effect.

## Timing
- Reset values: `out_bit=0`, `out_valid=0`, `busy=0`, `done=0`, state IDLE, shift register and counter 0.
- `rst` takes priority over every other input in every state. It aborts a transfer mid-stream with no `done` pulse.
- `start` is accepted in cycle T. The first bit is valid in T+1.
- With `ready` held high, bit k (k=0..N-1) is valid in T+1+k.
  - Without parity: `done` in T+1+N.
  - With parity: parity bit in T+1+N, `done` in T+2+N.
- Each cycle of `ready=0` while `out_valid=1` adds exactly one cycle of latency.
- Earliest next `start` is accepted in T+2+N without parity, or T+3+N with parity. That is the cycle after `done`, once back in IDLE.
- All outputs are registered. No combinational path runs from any input to any output.

## Configuration
- `SEQGEN_PARITY_EN` defined:
  - The PAR state and parity accumulator are compiled in.
  - One extra even-parity bit is sent after the data, and the transfer is N+1 bits.
- `SEQGEN_PARITY_EN` undefined:
  - No PAR state and no parity register.
  - SHIFT goes straight to DONE, and the transfer is N bits.

## Structure
- Shared include `seq_defs.vh` holds:
  - the state encodings: IDLE=2'b00, SHIFT=2'b01, PAR=2'b10, DONE=2'b11;
  - the default `WIDTH`.
  - The detector side uses the same include.
- One sub-module, `seq_shift_reg`: a WIDTH-bit load/shift-left register with enable, exposing the MSB. The FSM, counter and parity logic live in `seq_generator`.

## Test plan
- Full-width transfer:
  - Stimulus: `rst` for 2 cycles, then `pattern=16'b1011_0000_1011_0000`, `len=0`, `start` pulse, `ready=1`.
  - Required: `out_bit` = 1,0,1,1,0,0,0,0,1,0,1,1,0,0,0,0 in cycles T+1..T+16, and `done` in T+17. With parity enabled, T+17 carries parity 0 and `done` moves to T+18.
- Short length:
  - Stimulus: `pattern=16'hB000`, `len=4`.
  - Required: bits 1,0,1,1, then `done`. With parity enabled, parity bit 1.
- Stall:
  - Stimulus: `ready=0` for 3 cycles at bit 2.
  - Required: `out_bit` stays 1 and `out_valid` stays 1 while stalled, and `done` is delayed by exactly 3 cycles.
- Start while busy:
  - Stimulus: `start` with `pattern=16'hFFFF` at T+5.
  - Required: the stream is unchanged, with no second transfer.
- Reset mid-transfer:
  - Stimulus: `rst` at T+6.
  - Required: next cycle all outputs are 0 and there is no `done`. A `start` in the cycle after `rst` falls begins a fresh transfer.
- Clamp:
  - Stimulus: `len=31` with `WIDTH=16`.
  - Required: behaves as `len=16`, with exactly 16 valid bits.

Source files
------------

// File: rtl/seq_generator_pkg.sv
// rtl/seq_generator_pkg.sv - shared state encodings and defaults for seq_generator
package seq_generator_pkg;

  localparam int SEQ_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_PAR   = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

  // A length of zero, or anything wider than the register, means the whole register.
  function automatic int unsigned seq_eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - load/shift-left register with enable, MSB exposed
module seq_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift_en) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/seq_generator.sv
// rtl/seq_generator.sv - serial MSB-first pattern generator; SEQGEN_PARITY_EN appends even parity
module seq_generator
  import seq_generator_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEFAULT,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  seq_state_e    r_state;
  logic [LW-1:0] r_cnt;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_done;
  logic          w_load;
  logic          w_shift;
  logic          w_msb;
  logic [LW-1:0] w_eff_len;

  assign w_load    = (r_state == ST_IDLE) && start;
  assign w_shift   = (r_state == ST_SHIFT) && ready;
  assign w_eff_len = LW'(seq_eff_len(32'(len), WIDTH));

  seq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift_en (w_shift),
    .i_d        (pattern),
    .o_msb      (w_msb)
  );

`ifdef SEQGEN_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= 1'b0;
    end else if (w_shift) begin
      r_parity <= r_parity ^ w_msb;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_SHIFT;
            r_cnt       <= w_eff_len;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ready) begin
            r_cnt <= r_cnt - LW'(1);
            if (r_cnt == LW'(1)) begin
`ifdef SEQGEN_PARITY_EN
              r_state     <= ST_PAR;
`else
              r_state     <= ST_DONE;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
`endif
            end
          end
        end
`ifdef SEQGEN_PARITY_EN
        ST_PAR: begin
          if (ready) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // out_bit is a pure select of registered state, so it holds steady during a stall.
`ifdef SEQGEN_PARITY_EN
  assign out_bit = (r_state == ST_PAR) ? r_parity : ((r_state == ST_SHIFT) && w_msb);
`else
  assign out_bit = (r_state == ST_SHIFT) && w_msb;
`endif

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_generator.sv
// tb/tb_seq_generator.sv - directed self-checking bench for seq_generator
module tb_seq_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        ready;
  logic        out_bit;
  logic        out_valid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc;

  seq_generator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .ready     (ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_bit"},   32'(out_bit),   32'd0);
  endtask

  // Checks n data bits of p with ready high, then the optional parity bit and the done pulse.
  task automatic run_bits(input string tag, input logic [15:0] p, input int n, input logic par);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bit"},   32'(out_bit),   32'(p[15-k]));
      chk({tag, "_busy"},  32'(busy),      32'd1);
      chk({tag, "_nodone"}, 32'(done),     32'd0);
      tick();
    end
`ifdef SEQGEN_PARITY_EN
    chk({tag, "_par_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_par_bit"},   32'(out_bit),   32'(par));
    tick();
`else
    chk({tag, "_par_unused"}, 32'(par), 32'(par));
    total--;
`endif
    chk({tag, "_done"},       32'(done),      32'd1);
    chk({tag, "_done_busy"},  32'(busy),      32'd1);
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; ready = 1'b0;
    tick(); tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Full-width transfer, len=0 means 16 bits
    pattern = 16'b1011_0000_1011_0000; len = 5'd0; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; pattern = 16'h1234; len = 5'd3;
    run_bits("full", 16'hB0B0, 16, 1'b0);
    tick();
    chk_idle("full_after");

    // Short length
    pattern = 16'hB000; len = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    run_bits("short", 16'hB000, 4, 1'b1);
    tick();
    chk_idle("short_after");

    // Stall three cycles on bit 2 (value 1); done slips by exactly three cycles
    pattern = 16'hB0B0; len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      chk("stall_pre_bit", 32'(out_bit), 32'(k == 0 ? 1 : 0));
      tick();
    end
    ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_bit",   32'(out_bit),   32'd1);
      chk("stall_valid", 32'(out_valid), 32'd1);
      tick();
    end
    ready = 1'b1;
    for (int k = 2; k < 16; k++) begin
      chk("stall_post_bit", 32'(out_bit), 32'(k == 2 || k == 3 || k == 8 || k == 10 || k == 11));
      tick();
    end
`ifdef SEQGEN_PARITY_EN
    chk("stall_par", 32'(out_bit), 32'd0);
    tick();
    chk("stall_cycles", 32'(cyc), 32'd20);
`else
    chk("stall_cycles", 32'(cyc), 32'd19);
`endif
    chk("stall_done", 32'(done), 32'd1);
    tick();
    chk_idle("stall_after");

    // Start while busy is ignored, and start in DONE is not queued
    pattern = 16'hB0B0; len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("busy_bit", 32'(out_bit), 32'(k == 0 || k == 2 || k == 3 || k == 8 || k == 10 || k == 11));
      if (k == 4) begin
        start = 1'b1; pattern = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
`ifdef SEQGEN_PARITY_EN
    chk("busy_par", 32'(out_bit), 32'd0);
    tick();
`endif
    chk("busy_done", 32'(done), 32'd1);
    start = 1'b1; pattern = 16'hFFFF;
    tick();
    start = 1'b0;
    chk_idle("done_start_ignored");
    tick();
    chk_idle("done_start_ignored2");

    // Reset mid-transfer, then a fresh start right after reset falls
    pattern = 16'hB0B0; len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    chk_idle("abort");
    rst = 1'b0; pattern = 16'hB000; len = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    run_bits("restart", 16'hB000, 4, 1'b1);
    tick();
    chk_idle("restart_after");

    // Length clamp: 31 behaves as 16
    pattern = 16'hA5A5; len = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    run_bits("clamp", 16'hA5A5, 16, 1'b0);
    tick();
    chk_idle("clamp_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
